// File: rtl/bypass_arbiter_pkg.sv
// Shared types and helpers for the bypass arbiter.
// Optional feature macro used by this slice: BYPASS_ARBITER_LOCK_EN.
package bypass_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    // Index that follows idx in a ring of n requesters.
    function automatic int next_ptr(input int idx, input int n);
        int r;
        if ((idx + 1) >= n) begin
            r = 0;
        end else begin
            r = idx + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bypass_arbiter_if.sv
// Requester and downstream handshake bundle for the bypass arbiter.
// Req_Lock exists only when BYPASS_ARBITER_LOCK_EN is defined.
interface bypass_arbiter_if
    import bypass_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]        Req_Valid;
    logic [NUM_REQ*DATA_W-1:0] Req_Data;
    logic [NUM_REQ-1:0]        Req_Ready;
`ifdef BYPASS_ARBITER_LOCK_EN
    logic [NUM_REQ-1:0]        Req_Lock;
`endif
    logic [DATA_W-1:0]         Output_Data;
    logic [ID_W-1:0]           Output_Id;
    logic                      Output_Valid;
    logic                      Output_Ready;

    // Requester/consumer side.
    modport master (
        output Req_Valid,
        output Req_Data,
        input  Req_Ready,
`ifdef BYPASS_ARBITER_LOCK_EN
        output Req_Lock,
`endif
        input  Output_Data,
        input  Output_Id,
        input  Output_Valid,
        output Output_Ready
    );

    // Arbiter side.
    modport slave (
        input  Req_Valid,
        input  Req_Data,
        output Req_Ready,
`ifdef BYPASS_ARBITER_LOCK_EN
        input  Req_Lock,
`endif
        output Output_Data,
        output Output_Id,
        output Output_Valid,
        input  Output_Ready
    );

endinterface

// File: rtl/bypass_arbiter_rr_select.sv
// Combinational round-robin picker: first valid requester at or after
// i_ptr, wrapping, returned both one-hot and as a binary index.
module rr_select
    import bypass_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_cand;
    logic            w_hit;

    // Walk the ring from the pointer and latch the first valid index.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = i_ptr;
        w_hit   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_hit  = i_valid[w_cand] & ~o_any;
            o_idx  = w_hit ? w_cand : o_idx;
            o_any  = o_any | w_hit;
            w_cand = ID_W'(next_ptr(int'(w_cand), NUM_REQ));
        end
        o_grant[o_idx] = o_any;
    end

endmodule

// File: rtl/bypass_arbiter.sv
// Round-robin arbiter and single-entry output register for the shared
// bypass datapath. Build option: BYPASS_ARBITER_LOCK_EN adds sticky
// grants for a requester that holds its Req_Lock bit.
module bypass_arbiter
    import bypass_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    bypass_arbiter_if.slave  bus
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [DATA_W-1:0]   r_out_data;
    logic [ID_W-1:0]     r_out_id;

    logic [NUM_REQ-1:0]  w_rr_grant;
    logic [ID_W-1:0]     w_rr_idx;
    logic                w_rr_any;
    logic [NUM_REQ-1:0]  w_win_grant;
    logic [ID_W-1:0]     w_win_idx;
    logic                w_win_any;
    logic                w_lock_hold;
    logic                w_free;
    logic                w_xfer;

`ifdef BYPASS_ARBITER_LOCK_EN
    logic                r_lock_active;
    logic [ID_W-1:0]     r_lock_owner;
`endif

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_select (
        .i_valid (bus.Req_Valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    // Pick the winner: a held lock overrides the round-robin choice.
    always_comb begin
        w_lock_hold = 1'b0;
`ifdef BYPASS_ARBITER_LOCK_EN
        w_lock_hold = r_lock_active & bus.Req_Lock[r_lock_owner]
                    & bus.Req_Valid[r_lock_owner];
`endif
        if (w_lock_hold) begin
`ifdef BYPASS_ARBITER_LOCK_EN
            w_win_idx   = r_lock_owner;
`else
            w_win_idx   = w_rr_idx;
`endif
            w_win_grant = NUM_REQ'(1) << w_win_idx;
            w_win_any   = 1'b1;
        end else begin
            w_win_idx   = w_rr_idx;
            w_win_grant = w_rr_grant;
            w_win_any   = w_rr_any;
        end
    end

    // Slot is free when empty or when the held word leaves this cycle;
    // reset suppresses every grant.
    always_comb begin
        w_free        = (r_state == ST_EMPTY) | bus.Output_Ready;
        w_xfer        = Reset_n & w_free & w_win_any;
        bus.Req_Ready = w_xfer ? w_win_grant : {NUM_REQ{1'b0}};
    end

    // Next state of the output slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end else if (bus.Output_Ready) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winning word/ID and advance the pointer past a fresh winner.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_out_data <= {DATA_W{1'b0}};
            r_out_id   <= {ID_W{1'b0}};
            r_rr_ptr   <= {ID_W{1'b0}};
        end else if (w_xfer) begin
            r_out_data <= bus.Req_Data[w_win_idx*DATA_W +: DATA_W];
            r_out_id   <= w_win_idx;
            if (!w_lock_hold) begin
                r_rr_ptr <= ID_W'(next_ptr(int'(w_win_idx), NUM_REQ));
            end
        end
    end

`ifdef BYPASS_ARBITER_LOCK_EN
    // Remember the last winner; drop the lock once a free cycle passes it by.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_lock_active <= 1'b0;
            r_lock_owner  <= {ID_W{1'b0}};
        end else if (w_xfer) begin
            r_lock_active <= 1'b1;
            r_lock_owner  <= w_win_idx;
        end else if (w_free) begin
            r_lock_active <= 1'b0;
        end
    end
`endif

    assign bus.Output_Data  = r_out_data;
    assign bus.Output_Id    = r_out_id;
    assign bus.Output_Valid = (r_state == ST_FULL);

endmodule
